// File: rtl/uart_rx_param.sv
// uart_rx_param
// Oversampling UART receiver. The line and the 8x-baud strobe source are
// synchronised into i_clk; each rising edge of the strobe is one tick.
// Bit cells are 8 ticks wide and are sampled mid-cell, LSB first, with
// optional even/odd parity and 1 or 2 checked stop bits.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9)
//   STOP_BITS   stop bits checked per frame (1..2)
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_baud8_clk  8x baud strobe source (rising edge = tick)
//   i_rx         serial line, idle high
//   i_parity     00/11 none, 01 even, 10 odd (captured at start of data)
//   i_ack        consumer acknowledge, clears o_rdy and o_ovr
//   o_data       last received word
//   o_rdy        o_data valid and unacknowledged
//   o_bsy        frame in progress
//   o_perr       parity error on o_data
//   o_ferr       framing error (stop bit low) on o_data
//   o_ovr        a frame was delivered while o_rdy was still high
//
// Build option: define UART_RX_MAJORITY_EN to decide each bit by majority
// of the samples at ticks 3, 4 and 5 of its cell instead of the single
// sample at tick 4.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the line
// START  | validating the start bit at mid-cell
// DATA   | shifting in DATA_BITS data bits
// PARITY | checking the parity bit
// STOP   | checking STOP_BITS stop bits, delivering on the last one
module uart_rx_param #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_baud8_clk,
    input  logic                 i_rx,
    input  logic [1:0]           i_parity,
    input  logic                 i_ack,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rdy,
    output logic                 o_bsy,
    output logic                 o_perr,
    output logic                 o_ferr,
    output logic                 o_ovr
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 baud_meta, baud_sync, baud_prev;
    logic                 tick, rx_fall, sample, bit_val, deliver;
    logic [2:0]           tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en, par_odd, perr_int, ferr_int;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            baud_meta <= 1'b0;
            baud_sync <= 1'b0;
            baud_prev <= 1'b0;
        end else begin
            rx_meta   <= i_rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            baud_meta <= i_baud8_clk;
            baud_sync <= baud_meta;
            baud_prev <= baud_sync;
        end
    end

    assign tick    = baud_sync & ~baud_prev;
    assign rx_fall = rx_prev & ~rx_sync;

    // tick_cnt counts ticks since the start edge, modulo one cell. The
    // decision tick is the last sample tick of a cell; the counter keeps
    // running so the next decision lands exactly 8 ticks later.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [2:0] DECIDE_CNT = 3'd4;
    logic samp_3, samp_4;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            samp_3 <= 1'b1;
            samp_4 <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == 3'd2) samp_3 <= rx_sync;
            if (tick_cnt == 3'd3) samp_4 <= rx_sync;
        end
    end

    assign bit_val = (samp_3 & samp_4) | (samp_3 & rx_sync) | (samp_4 & rx_sync);
`else
    localparam logic [2:0] DECIDE_CNT = 3'd3;
    assign bit_val = rx_sync;
`endif

    assign sample  = tick && (tick_cnt == DECIDE_CNT) && (state != S_IDLE);
    assign deliver = (state == S_STOP) && sample && (bit_cnt == LAST_STOP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rx_fall) state_nxt = S_START;
            S_START:  if (sample) state_nxt = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (sample && bit_cnt == LAST_DATA)
                          state_nxt = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (sample) state_nxt = S_STOP;
            S_STOP:   if (deliver) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_bsy = (state != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            perr_int <= 1'b0;
            ferr_int <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 3'd1;
            end
            if (sample) begin
                case (state)
                    S_START: begin
                        par_en   <= i_parity[0] ^ i_parity[1];
                        par_odd  <= i_parity[1];
                        perr_int <= 1'b0;
                        ferr_int <= 1'b0;
                        bit_cnt  <= '0;
                    end
                    S_DATA: begin
                        shift   <= {bit_val, shift[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
                    end
                    S_PARITY: perr_int <= bit_val ^ (^shift) ^ par_odd;
                    S_STOP: begin
                        ferr_int <= ferr_int | ~bit_val;
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A delivery always wins over a coincident acknowledge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_rdy  <= 1'b0;
            o_perr <= 1'b0;
            o_ferr <= 1'b0;
            o_ovr  <= 1'b0;
        end else if (deliver) begin
            o_data <= shift;
            o_perr <= perr_int;
            o_ferr <= ferr_int | ~bit_val;
            o_rdy  <= 1'b1;
            if (o_rdy && !i_ack) o_ovr <= 1'b1;
        end else if (i_ack) begin
            o_rdy <= 1'b0;
            o_ovr <= 1'b0;
        end
    end
endmodule
